// File: rtl/bsort_main.sv
// Bubble-sort kernel: on start, fills a signed word array with -1..-N, sorts it ascending, pulses done.
// Two-channel slave port gives the array to an external master while idle; responses arrive one cycle after the request.
module bsort_main #(
  parameter int MEM_var_26078_26084 = 256,
  parameter int N_ELEMS             = 20
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start_port,
  input  logic [1:0]   S_oe_ram,
  input  logic [1:0]   S_we_ram,
  input  logic [19:0]  S_addr_ram,
  input  logic [127:0] S_Wdata_ram,
  input  logic [13:0]  S_data_ram_size,
  output logic         done_port,
  output logic [127:0] Sout_Rdata_ram,
  output logic [1:0]   Sout_DataRdy
);

  localparam int IW = $clog2(N_ELEMS);
  localparam logic [31:0] BASE  = 32'(MEM_var_26078_26084);
  localparam logic [31:0] LIMIT = 32'(MEM_var_26078_26084 + 4 * N_ELEMS);

  typedef enum logic [2:0] {IDLE, INIT, PASS, PEND, DONE} state_t;

  state_t            state, state_nxt;
  logic signed [31:0] arr [N_ELEMS];
  logic [IW-1:0]     pass, j, j_nxt, last_j;
  logic              swapped;
  logic              pass_end, sort_end;

  logic [1:0]        rd_hit, wr_hit;
  logic [IW-1:0]     s_idx [2];

  // Only the low word of each write lane carries data.
  logic unused_wdata_hi;
  assign unused_wdata_hi = ^{S_Wdata_ram[127:96], S_Wdata_ram[63:32]};

  assign j_nxt    = j + IW'(1);
  assign last_j   = IW'(N_ELEMS - 1) - pass;
  assign pass_end = (j == last_j);
  assign sort_end = !swapped || (pass == IW'(N_ELEMS - 1));

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_port = 1'b0;
    case (state)
      IDLE: if (start_port) state_nxt = INIT;
      INIT: state_nxt = PASS;
      PASS: if (pass_end) state_nxt = PEND;
      PEND: state_nxt = sort_end ? DONE : PASS;
      DONE: begin
        done_port = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [31:0] addr;
    logic        acc;
    assign addr      = 32'(S_addr_ram[10*c +: 10]);
    assign acc       = (state == IDLE) && (addr >= BASE) && (addr < LIMIT) &&
                       (addr[1:0] == 2'b00) && (S_data_ram_size[7*c +: 7] == 7'd32);
    assign wr_hit[c] = acc && S_we_ram[c];
    assign rd_hit[c] = acc && S_oe_ram[c] && !S_we_ram[c];
    assign s_idx[c]  = IW'((addr - BASE) >> 2);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < N_ELEMS; k++) arr[k] <= '0;
      pass    <= '0;
      j       <= '0;
      swapped <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Channel 1 is applied last so it wins a same-word collision.
          for (int c = 0; c < 2; c++)
            if (wr_hit[c]) arr[s_idx[c]] <= S_Wdata_ram[64*c +: 32];
        end
        INIT: begin
          for (int k = 0; k < N_ELEMS; k++) arr[k] <= 32'(-(k + 1));
          pass    <= IW'(1);
          j       <= '0;
          swapped <= 1'b0;
        end
        PASS: begin
          if (arr[j] > arr[j_nxt]) begin
            arr[j]     <= arr[j_nxt];
            arr[j_nxt] <= arr[j];
            swapped    <= 1'b1;
          end
          j <= j_nxt;
        end
        PEND: begin
          if (!sort_end) begin
            pass    <= pass + IW'(1);
            j       <= '0;
            swapped <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      Sout_DataRdy   <= '0;
      Sout_Rdata_ram <= '0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        Sout_DataRdy[c]            <= rd_hit[c] | wr_hit[c];
        Sout_Rdata_ram[64*c +: 64] <= rd_hit[c] ? {32'h0, arr[s_idx[c]]} : 64'h0;
      end
    end
  end

endmodule

// File: tb/tb_bsort_main.sv
// Directed bench for bsort_main: latency, sorted contents, slave port hits/misses, reset abort.
module tb_bsort_main;

  logic         clock = 1'b0;
  logic         reset;
  logic         start_port;
  logic [1:0]   S_oe_ram, S_we_ram;
  logic [19:0]  S_addr_ram;
  logic [127:0] S_Wdata_ram;
  logic [13:0]  S_data_ram_size;
  logic         done_port;
  logic [127:0] Sout_Rdata_ram;
  logic [1:0]   Sout_DataRdy;

  int total = 0;
  int bad   = 0;

  bsort_main dut (
    .clock(clock), .reset(reset), .start_port(start_port),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .done_port(done_port), .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          ch;
    bit          oe;
    bit          we;
    int          addr;
    int          size;
    logic [31:0] wd;
    bit          exp_rdy;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_slave();
    S_oe_ram = '0; S_we_ram = '0; S_addr_ram = '0;
    S_Wdata_ram = '0; S_data_ram_size = '0;
  endtask

  task automatic access(input int ch, input bit oe, input bit we, input int addr,
                        input int size, input logic [31:0] wd);
    clear_slave();
    S_oe_ram[ch] = oe;
    S_we_ram[ch] = we;
    S_addr_ram[10*ch +: 10] = 10'(addr);
    S_data_ram_size[7*ch +: 7] = 7'(size);
    S_Wdata_ram[64*ch +: 32] = wd;
    @(posedge clock); #1;
    clear_slave();
  endtask

  function automatic vec_t mk(int ch, bit oe, bit we, int addr, int size,
                              logic [31:0] wd, bit er, logic [31:0] ed);
    vec_t v;
    v.ch = ch; v.oe = oe; v.we = we; v.addr = addr; v.size = size;
    v.wd = wd; v.exp_rdy = er; v.exp_dat = ed;
    return v;
  endfunction

  task automatic verify_words(input string tag, input bit zeros);
    logic [127:0] exp;
    logic [31:0]  w;
    for (int k = 0; k < 20; k++) begin
      access(0, 1'b1, 1'b0, 256 + 4*k, 32, 32'h0);
      w = zeros ? 32'h0 : 32'(-20 + k);
      exp = {64'h0, 32'h0, w};
      check($sformatf("%s_rdy_%0d", tag, k), {126'h0, Sout_DataRdy}, 128'h1);
      check($sformatf("%s_dat_%0d", tag, k), Sout_Rdata_ram, exp);
    end
  endtask

  // Pulses start and watches up to 400 cycles; cycle 1 is the one right after the start edge.
  task automatic run_sort(input int extra_a, input int extra_b, input int slave_at, input int reset_at,
                          output int first_done, output int n_done, output int slv_bad);
    first_done = 0; n_done = 0; slv_bad = 0;
    start_port = 1'b1;
    @(posedge clock); #1;
    start_port = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      if (done_port) begin
        n_done++;
        if (first_done == 0) first_done = c;
      end
      if (Sout_DataRdy != 2'b00 || Sout_Rdata_ram != '0) slv_bad++;
      start_port = (c == extra_a || c == extra_b);
      reset = (c == reset_at);
      if (c == slave_at) begin
        S_we_ram = 2'b01; S_oe_ram = 2'b10;
        S_addr_ram = {10'd256, 10'd260};
        S_data_ram_size = {7'd32, 7'd32};
        S_Wdata_ram[31:0] = 32'd123;
      end else begin
        clear_slave();
      end
      @(posedge clock); #1;
    end
    start_port = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    int fd, nd, sb;
    logic [127:0] exp;

    reset = 1'b1; start_port = 1'b0;
    clear_slave();
    repeat (2) @(posedge clock);
    #1;
    check("reset_done", {127'h0, done_port}, 128'h0);
    check("reset_rdy", {126'h0, Sout_DataRdy}, 128'h0);
    check("reset_rdata", Sout_Rdata_ram, 128'h0);
    reset = 1'b0;
    @(posedge clock); #1;

    run_sort(0, 0, 0, 0, fd, nd, sb);
    check("run1_latency", 128'(fd), 128'd211);
    check("run1_done_count", 128'(nd), 128'd1);
    check("run1_slave_quiet", 128'(sb), 128'd0);

    for (int k = 0; k < 20; k++)
      tbl.push_back(mk(0, 1, 0, 256 + 4*k, 32, 32'h0, 1, 32'(-20 + k)));
    tbl.push_back(mk(1, 1, 0, 332, 32, 32'h0, 1, 32'hFFFFFFFF));
    tbl.push_back(mk(1, 0, 1, 256, 32, 32'd5, 1, 32'h0));
    tbl.push_back(mk(0, 1, 0, 256, 32, 32'h0, 1, 32'd5));
    tbl.push_back(mk(0, 1, 0, 252, 32, 32'h0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 336, 32, 32'h0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 256, 16, 32'h0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 258, 32, 32'h0, 0, 32'h0));
    tbl.push_back(mk(0, 1, 1, 264, 32, 32'd77, 1, 32'h0));
    tbl.push_back(mk(1, 1, 0, 264, 32, 32'h0, 1, 32'd77));
    tbl.push_back(mk(1, 0, 1, 268, 8, 32'd99, 0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 268, 32, 32'h0, 1, 32'hFFFFFFEF));

    foreach (tbl[i]) begin
      access(tbl[i].ch, tbl[i].oe, tbl[i].we, tbl[i].addr, tbl[i].size, tbl[i].wd);
      exp = '0;
      exp[64*tbl[i].ch +: 32] = tbl[i].exp_dat;
      check($sformatf("vec%0d_rdy", i), {126'h0, Sout_DataRdy},
            128'(tbl[i].exp_rdy) << tbl[i].ch);
      check($sformatf("vec%0d_dat", i), Sout_Rdata_ram, exp);
    end

    // Second run with stray start pulses mid-sort and in the done cycle.
    run_sort(5, 211, 0, 0, fd, nd, sb);
    check("run2_latency", 128'(fd), 128'd211);
    check("run2_done_count", 128'(nd), 128'd1);
    verify_words("run2", 1'b0);

    // Same-word collision: channel 1 must win.
    clear_slave();
    S_we_ram = 2'b11;
    S_addr_ram = {10'd260, 10'd260};
    S_data_ram_size = {7'd32, 7'd32};
    S_Wdata_ram[31:0] = 32'd7;
    S_Wdata_ram[95:64] = 32'd9;
    @(posedge clock); #1;
    clear_slave();
    check("collide_rdy", {126'h0, Sout_DataRdy}, 128'h3);
    access(0, 1'b1, 1'b0, 260, 32, 32'h0);
    check("collide_dat", Sout_Rdata_ram, 128'd9);

    // Reset 50 cycles into a sort aborts it and clears the array.
    run_sort(0, 0, 0, 50, fd, nd, sb);
    check("abort_done_count", 128'(nd), 128'd0);
    verify_words("abort", 1'b1);
    run_sort(0, 0, 0, 0, fd, nd, sb);
    check("after_abort_latency", 128'(fd), 128'd211);
    check("after_abort_done_count", 128'(nd), 128'd1);

    // Slave traffic during the sort is ignored.
    run_sort(0, 0, 30, 0, fd, nd, sb);
    check("busy_slave_quiet", 128'(sb), 128'd0);
    check("busy_latency", 128'(fd), 128'd211);
    verify_words("busy", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
